chan_fifo_wr_demux: RTL and testbench

Write-side demultiplexer for the 80-channel FIFO bank drained by the round-robin output selector. It accepts a channel-tagged 395-bit word stream through a valid/ready handshake and holds each word in a one-entry output register. It then writes that word into the addressed per-channel FIFO, stalling while that FIFO is full. It also asserts the selector's `start` once the bank holds enough data, and counts words it discards.

---
 rtl/chan_fifo_wr_demux_pkg.sv | 13 +
 rtl/chan_fifo_wr_demux_if.sv | 29 ++
 rtl/chan_fifo_wr_demux_dec.sv | 17 +
 rtl/chan_fifo_wr_demux.sv | 109 ++++++++++
 tb/tb_chan_fifo_wr_demux.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_fifo_wr_demux_pkg.sv
// Shared definitions for the channel FIFO bank write demux and its output selector.
package chan_fifo_wr_demux_pkg;

    localparam int NUM_CH_DEFAULT = 80;
    localparam int CHID_W_DEFAULT = 7;
    localparam int DATA_W_DEFAULT = 395;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } start_state_t;

endpackage

// File: rtl/chan_fifo_wr_demux_if.sv
// Upstream word handshake plus the per-channel FIFO write port bundle.
interface chan_fifo_wr_demux_if
    import chan_fifo_wr_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CHID_W = CHID_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              in_valid;
    logic              in_ready;
    logic [CHID_W-1:0] in_chid;
    logic [DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_write_enable;
    logic [DATA_W-1:0] fifo_write_data;

    // master is the upstream source and FIFO bank; slave is the demux
    modport master (
        output in_valid, in_chid, in_data, fifo_full,
        input  in_ready, fifo_write_enable, fifo_write_data
    );

    modport slave (
        input  in_valid, in_chid, in_data, fifo_full,
        output in_ready, fifo_write_enable, fifo_write_data
    );

endinterface

// File: rtl/chan_fifo_wr_demux_dec.sv
// Channel id to one-hot strobe decoder with enable; shared with the selector read side.
module chid_onehot_dec
    import chan_fifo_wr_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CHID_W = CHID_W_DEFAULT
) (
    input  logic              en,
    input  logic [CHID_W-1:0] chid,
    output logic [NUM_CH-1:0] onehot
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_bit
        assign onehot[i] = en && (chid == CHID_W'(i));
    end

endmodule

// File: rtl/chan_fifo_wr_demux.sv
// Write-side demux: one-entry holding register feeding the addressed channel FIFO,
// plus the start handshake to the output selector and drop/error bookkeeping.
module chan_fifo_wr_demux
    import chan_fifo_wr_demux_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEFAULT,
    parameter int CHID_W       = CHID_W_DEFAULT,
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int START_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    chan_fifo_wr_demux_if.slave  bus,
    output logic                 start,
    output logic [15:0]          drop_count,
    output logic                 err_chid
);

    localparam logic [CHID_W:0] CHID_LIMIT = (CHID_W + 1)'(NUM_CH);
    localparam logic [15:0]     THRESH     = 16'(START_THRESH);

    logic              hold_valid;
    logic [CHID_W-1:0] hold_chid;
    logic [DATA_W-1:0] hold_data;
    logic              wr_fire;
    logic              accept;
    logic              bad_chid;

    start_state_t      state;
    start_state_t      state_next;
    logic [15:0]       wr_count;
    logic [15:0]       wr_count_next;

    assign bad_chid              = {1'b0, bus.in_chid} >= CHID_LIMIT;
    assign wr_fire               = hold_valid && !bus.fifo_full[hold_chid];
    assign bus.in_ready          = !hold_valid || wr_fire;
    assign accept                = bus.in_valid && bus.in_ready;
    assign bus.fifo_write_data   = hold_data;
    assign start                 = (state == ST_RUN);

    chid_onehot_dec #(
        .NUM_CH (NUM_CH),
        .CHID_W (CHID_W)
    ) u_wr_dec (
        .en     (wr_fire),
        .chid   (hold_chid),
        .onehot (bus.fifo_write_enable)
    );

    // Bad ids are swallowed without loading, so hold_chid is always a legal index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_chid  <= '0;
            hold_data  <= '0;
        end else if (accept && !bad_chid) begin
            hold_valid <= 1'b1;
            hold_chid  <= bus.in_chid;
            hold_data  <= bus.in_data;
        end else if (wr_fire) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            err_chid   <= 1'b0;
        end else if (accept && bad_chid) begin
            err_chid <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_count <= '0;
        end else begin
            state    <= state_next;
            wr_count <= wr_count_next;
        end
    end

    // Count completed writes until the threshold, then latch RUN until reset
    always_comb begin
        state_next    = state;
        wr_count_next = wr_count;
        case (state)
            ST_IDLE: begin
                if (wr_fire) begin
                    wr_count_next = wr_count + 16'd1;
                    if (wr_count_next == THRESH) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_chan_fifo_wr_demux.sv
// Directed bench for chan_fifo_wr_demux: reset, single write, streaming with stall,
// bad channel ids, start threshold and drop counter saturation.
module tb_chan_fifo_wr_demux;
    import chan_fifo_wr_demux_pkg::*;

    localparam int NUM_CH = 80;
    localparam int CHID_W = 7;
    localparam int DATA_W = 395;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] drop_count;
    logic        err_chid;

    int checks = 0;
    int errors = 0;

    chan_fifo_wr_demux_if #(.NUM_CH(NUM_CH), .CHID_W(CHID_W), .DATA_W(DATA_W)) bus ();

    chan_fifo_wr_demux #(
        .NUM_CH       (NUM_CH),
        .CHID_W       (CHID_W),
        .DATA_W       (DATA_W),
        .START_THRESH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .start      (start),
        .drop_count (drop_count),
        .err_chid   (err_chid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_chid   = '0;
        bus.in_data   = '0;
        bus.fifo_full = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_chid   = '0;
        bus.in_data   = '0;
        bus.fifo_full = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fifo_write_enable !== '0 || start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b fwe=%h start=%b, want 1/0/0",
                     bus.in_ready, bus.fifo_write_enable, start);
        end
        // a bad id to dirty the counters, then a word that stalls
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_chid  = 7'd100;
        @(negedge clk);
        bus.in_chid      = 7'd3;
        bus.in_data      = 395'hABC;
        bus.fifo_full[3] = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.fifo_write_enable !== '0 || drop_count !== 16'd1 ||
            err_chid !== 1'b1 || bus.fifo_write_data !== 395'hABC) begin
            errors++;
            $display("[TB] FAIL pre_reset_stall: in_ready=%b fwe=%h drop=%0d err=%b data=%h, want 0/0/1/1/abc",
                     bus.in_ready, bus.fifo_write_enable, drop_count, err_chid, bus.fifo_write_data[31:0]);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fifo_write_enable !== '0 || bus.fifo_write_data !== '0 ||
            start !== 1'b0 || drop_count !== 16'd0 || err_chid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: in_ready=%b fwe=%h data=%h start=%b drop=%0d err=%b, want 1/0/0/0/0/0",
                     bus.in_ready, bus.fifo_write_enable, bus.fifo_write_data[31:0], start, drop_count, err_chid);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.fifo_full = '0;
    endtask

    task automatic test_start_threshold;
        do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_chid  = 7'd2;
        bus.in_data  = 395'h55;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) bus.in_valid = 1'b0;
            #1;
            checks++;
            if (start !== ((k - 1) >= 4)) begin
                errors++;
                $display("[TB] FAIL start_after_%0d_writes: start=%b, want %b", k - 1, start, ((k - 1) >= 4));
            end
        end
        // start must survive a stall
        bus.in_valid     = 1'b1;
        bus.in_chid      = 7'd9;
        bus.fifo_full[9] = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (start !== 1'b1 || bus.in_ready !== 1'b0 || bus.fifo_write_enable !== '0) begin
                errors++;
                $display("[TB] FAIL start_hold_stall: start=%b in_ready=%b fwe=%h, want 1/0/0",
                         start, bus.in_ready, bus.fifo_write_enable);
            end
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_cleared_by_reset: start=%b, want 0", start);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.fifo_full = '0;
    endtask

    task automatic test_single_write;
        logic [NUM_CH-1:0] exp;
        exp = '0;
        exp[5] = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_chid  = 7'd5;
        bus.in_data  = 395'h1234;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.fifo_write_enable !== exp || bus.fifo_write_data !== 395'h1234) begin
            errors++;
            $display("[TB] FAIL single_write: fwe=%h data=%h, want %h/1234",
                     bus.fifo_write_enable, bus.fifo_write_data[31:0], exp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.fifo_write_enable !== '0) begin
            errors++;
            $display("[TB] FAIL single_write_one_cycle: fwe=%h, want 0", bus.fifo_write_enable);
        end
    endtask

    task automatic test_streaming;
        logic [NUM_CH-1:0] exp;
        for (int i = 0; i < NUM_CH; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_chid  = 7'(i);
            bus.in_data  = 395'(i + 256);
            #1;
            if (i > 0) begin
                exp = '0;
                exp[i-1] = 1'b1;
                checks++;
                if (bus.fifo_write_enable !== exp || bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stream_ch%0d: fwe=%h in_ready=%b, want %h/1",
                             i - 1, bus.fifo_write_enable, bus.in_ready, exp);
                end
            end
        end
        @(negedge clk);
        bus.fifo_full[79] = 1'b1;
        bus.in_chid       = 7'd0;
        bus.in_data       = 395'hBEEF;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.fifo_write_enable !== '0) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: in_ready=%b fwe=%h, want 0/0",
                         k, bus.in_ready, bus.fifo_write_enable);
            end
        end
        @(negedge clk);
        bus.fifo_full[79] = 1'b0;
        #1;
        exp = '0;
        exp[79] = 1'b1;
        checks++;
        if (bus.fifo_write_enable !== exp || bus.fifo_write_data !== 395'(79 + 256) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: fwe=%h data=%h in_ready=%b, want %h/14f/1",
                     bus.fifo_write_enable, bus.fifo_write_data[31:0], bus.in_ready, exp);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        exp = '0;
        exp[0] = 1'b1;
        checks++;
        if (bus.fifo_write_enable !== exp || bus.fifo_write_data !== 395'hBEEF) begin
            errors++;
            $display("[TB] FAIL after_stall_word: fwe=%h data=%h, want %h/beef",
                     bus.fifo_write_enable, bus.fifo_write_data[31:0], exp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.fifo_write_enable !== '0) begin
            errors++;
            $display("[TB] FAIL stream_idle: fwe=%h, want 0", bus.fifo_write_enable);
        end
    endtask

    task automatic test_bad_chid;
        logic [NUM_CH-1:0] exp;
        do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_chid  = 7'd80;
        @(negedge clk);
        bus.in_chid = 7'd127;
        #1;
        checks++;
        if (bus.fifo_write_enable !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad80_no_strobe: fwe=%h in_ready=%b, want 0/1", bus.fifo_write_enable, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (drop_count !== 16'd2 || err_chid !== 1'b1 || bus.fifo_write_enable !== '0) begin
            errors++;
            $display("[TB] FAIL bad_ids: drop=%0d err=%b fwe=%h, want 2/1/0", drop_count, err_chid, bus.fifo_write_enable);
        end
        // bad id accepted while a good word drains: holding register empties
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_chid  = 7'd10;
        bus.in_data  = 395'h77;
        @(negedge clk);
        bus.in_chid = 7'd90;
        #1;
        exp = '0;
        exp[10] = 1'b1;
        checks++;
        if (bus.fifo_write_enable !== exp) begin
            errors++;
            $display("[TB] FAIL drain_with_bad: fwe=%h, want %h", bus.fifo_write_enable, exp);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.fifo_write_enable !== '0 || drop_count !== 16'd3 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_cleared_on_bad: fwe=%h drop=%0d in_ready=%b, want 0/3/1",
                     bus.fifo_write_enable, drop_count, bus.in_ready);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_chid  = 7'd127;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (drop_count !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL drop_reach_max: drop=%h, want ffff", drop_count);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (drop_count !== 16'hFFFF || err_chid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_saturate: drop=%h err=%b, want ffff/1", drop_count, err_chid);
        end
    endtask

    initial begin
        test_reset();
        test_start_threshold();
        test_single_write();
        test_streaming();
        test_bad_chid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
